// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared definitions for the exception/ERET redirect controller:
// exception codes and FSM state encoding.
package exc_redirect_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/exc_redirect_ctrl_req_tracker.sv
// Tracks in-flight instruction-bus requests and how many of them belong to
// fetches squashed by the last redirect, so their responses can be dropped.
module exc_redirect_ctrl_req_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req_fire,
  input  logic inst_resp_fire,
  input  logic load_disc,
  output logic drop_resp
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_next;
  logic [CW-1:0] disc_cnt;

  // Saturating up/down count; simultaneous request and response cancel out.
  always_comb begin
    out_cnt_next = out_cnt;
    if (inst_req_fire && !inst_resp_fire) begin
      if (out_cnt != MAX_CNT) out_cnt_next = out_cnt + 1'b1;
    end else if (!inst_req_fire && inst_resp_fire) begin
      if (out_cnt != '0) out_cnt_next = out_cnt - 1'b1;
    end
  end

  assign drop_resp = inst_resp_fire && (disc_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      out_cnt <= out_cnt_next;
      // Loading the post-update count keeps disc_cnt bounded by out_cnt.
      if (load_disc) disc_cnt <= out_cnt_next;
      else if (drop_resp) disc_cnt <= disc_cnt - 1'b1;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
    !(inst_req_fire && !inst_resp_fire && out_cnt == MAX_CNT));

  a_no_underflow : assert property (@(posedge clk) disable iff (!resetn)
    !(inst_resp_fire && !inst_req_fire && out_cnt == '0));

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Sequences flushes, CP0 commit strobes and the fetch PC redirect when an
// exception or ERET resolves in M; squashed fetch responses are dropped.
module exc_redirect_ctrl #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] excepttypeM,
  input  logic [31:0] newpcM,
  input  logic        validM,
  input  logic        stallM,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        fetch_ready,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        exc_commit,
  output logic        eret_commit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        drop_resp
);

  import exc_redirect_ctrl_pkg::*;

  state_t state;
  logic   take;
  logic   is_eret;

  // Gating with resetn keeps every output quiet while reset is held.
  assign take    = resetn && validM && !stallM && (excepttypeM != EXC_NONE) &&
                   (state == ST_IDLE);
  assign is_eret = (excepttypeM == EXC_ERET);

  assign flushF = take;
  assign flushD = take;
  assign flushE = take;
  assign flushM = take;
  assign flushW = 1'b0;

  assign exc_commit  = take && !is_eret;
  assign eret_commit = take && is_eret;

  assign redirect_valid = (state == ST_REDIRECT);
  assign busy           = redirect_valid || take;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state       <= ST_REDIRECT;
            redirect_pc <= newpcM;
          end
        end
        ST_REDIRECT: begin
          if (fetch_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  exc_redirect_ctrl_req_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_req_tracker (
    .clk           (clk),
    .resetn        (resetn),
    .inst_req_fire (inst_req_fire),
    .inst_resp_fire(inst_resp_fire),
    .load_disc     (take),
    .drop_resp     (drop_resp)
  );

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed self-checking bench for exc_redirect_ctrl.
module tb_exc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] excepttypeM;
  logic [31:0] newpcM;
  logic        validM, stallM, inst_req_fire, inst_resp_fire, fetch_ready;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        exc_commit, eret_commit, redirect_valid, busy, drop_resp;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // Control bundle bit order: F D E M W exc eret rv busy drop
  logic [9:0] ctl;
  assign ctl = {flushF, flushD, flushE, flushM, flushW,
                exc_commit, eret_commit, redirect_valid, busy, drop_resp};

  localparam logic [9:0] CTL_IDLE = 10'b00000_00000;
  localparam logic [9:0] CTL_EXC  = 10'b11110_10010;
  localparam logic [9:0] CTL_ERET = 10'b11110_01010;
  localparam logic [9:0] CTL_PEND = 10'b00000_00110;
  localparam logic [9:0] CTL_DROP = 10'b00000_00001;

  always #5 clk = ~clk;

  exc_redirect_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn), .excepttypeM(excepttypeM), .newpcM(newpcM),
    .validM(validM), .stallM(stallM), .inst_req_fire(inst_req_fire),
    .inst_resp_fire(inst_resp_fire), .fetch_ready(fetch_ready),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW), .exc_commit(exc_commit), .eret_commit(eret_commit),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .drop_resp(drop_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    excepttypeM    = 32'h0;
    newpcM         = 32'h0;
    validM         = 1'b0;
    stallM         = 1'b0;
    inst_req_fire  = 1'b0;
    inst_resp_fire = 1'b0;
    fetch_ready    = 1'b0;
  endtask

  task automatic present_exc(input logic [31:0] code, input logic [31:0] pc);
    excepttypeM = code;
    newpcM      = pc;
    validM      = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL reset_ctl got %b exp %b", ctl, CTL_IDLE);
    end
    checks++;
    if (redirect_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc got %h exp %h", redirect_pc, 32'h0);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_syscall();
    present_exc(32'h08, 32'hbfc00380);
    #1;
    checks++;
    if (ctl !== CTL_EXC) begin
      errors++; $display("[TB] FAIL sys_T_ctl got %b exp %b", ctl, CTL_EXC);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
      errors++; $display("[TB] FAIL sys_T1 got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
    end
    tick(); fetch_ready = 1'b1; #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
      errors++; $display("[TB] FAIL sys_T2 got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL sys_T3_ctl got %b exp %b", ctl, CTL_IDLE);
    end
    tick();
  endtask

  task automatic test_eret_back_to_back();
    present_exc(32'h0e, 32'h80001234);
    #1;
    checks++;
    if (ctl !== CTL_ERET) begin
      errors++; $display("[TB] FAIL eret_T_ctl got %b exp %b", ctl, CTL_ERET);
    end
    tick(); clear_inputs(); fetch_ready = 1'b1; #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'h80001234) begin
      errors++; $display("[TB] FAIL eret_T1 got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'h80001234);
    end
    tick(); clear_inputs(); present_exc(32'h0a, 32'hbfc00380); #1;
    checks++;
    if (ctl !== CTL_EXC) begin
      errors++; $display("[TB] FAIL b2b_take_ctl got %b exp %b", ctl, CTL_EXC);
    end
    tick(); clear_inputs(); fetch_ready = 1'b1; #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
      errors++; $display("[TB] FAIL b2b_T1 got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL b2b_exit_ctl got %b exp %b", ctl, CTL_IDLE);
    end
    tick();
  endtask

  task automatic test_discard();
    inst_req_fire = 1'b1;
    tick();
    tick();
    present_exc(32'h0c, 32'hbfc00380);
    #1;
    checks++;
    if (ctl !== CTL_EXC) begin
      errors++; $display("[TB] FAIL disc_take_ctl got %b exp %b", ctl, CTL_EXC);
    end
    tick(); clear_inputs(); fetch_ready = 1'b1; #1;
    checks++;
    if (ctl !== CTL_PEND) begin
      errors++; $display("[TB] FAIL disc_T1_ctl got %b exp %b", ctl, CTL_PEND);
    end
    // First stale response arrives together with a fresh request.
    tick(); clear_inputs(); inst_req_fire = 1'b1; inst_resp_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_DROP) begin
        errors++; $display("[TB] FAIL disc_drop%0d got %b exp %b", i, ctl, CTL_DROP);
      end
      tick(); clear_inputs(); inst_resp_fire = 1'b1;
    end
    #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL disc_keep4 got %b exp %b", ctl, CTL_IDLE);
    end
    tick(); clear_inputs();
  endtask

  task automatic test_stall();
    present_exc(32'h04, 32'hbfc00380);
    stallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_IDLE) begin
        errors++; $display("[TB] FAIL stall_c%0d got %b exp %b", i, ctl, CTL_IDLE);
      end
      tick();
    end
    stallM = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_EXC) begin
      errors++; $display("[TB] FAIL stall_take got %b exp %b", ctl, CTL_EXC);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
      errors++; $display("[TB] FAIL stall_T1 got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
    end
    tick();
  endtask

  task automatic test_ignore_in_redirect();
    for (int i = 0; i < 5; i++) begin
      present_exc(32'h0c, 32'hdeadbeef);
      #1;
      checks++;
      if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
        errors++; $display("[TB] FAIL ignore_c%0d got %b/%h exp %b/%h", i, ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
      end
      tick();
    end
    clear_inputs(); fetch_ready = 1'b1; #1;
    checks++;
    if (ctl !== CTL_PEND || redirect_pc !== 32'hbfc00380) begin
      errors++; $display("[TB] FAIL ignore_exit got %b/%h exp %b/%h", ctl, redirect_pc, CTL_PEND, 32'hbfc00380);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL ignore_idle got %b exp %b", ctl, CTL_IDLE);
    end
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    inst_req_fire = 1'b1;
    tick();
    tick();
    clear_inputs();
    present_exc(32'h08, 32'hbfc00380);
    #1;
    checks++;
    if (ctl !== CTL_EXC) begin
      errors++; $display("[TB] FAIL rst_take got %b exp %b", ctl, CTL_EXC);
    end
    tick(); clear_inputs(); #1;
    checks++;
    if (ctl !== CTL_PEND) begin
      errors++; $display("[TB] FAIL rst_T1 got %b exp %b", ctl, CTL_PEND);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_IDLE || redirect_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_async got %b/%h exp %b/%h", ctl, redirect_pc, CTL_IDLE, 32'h0);
    end
    tick(); tick();
    resetn = 1'b1;
    tick();
    inst_req_fire = 1'b1;
    tick(); clear_inputs(); inst_resp_fire = 1'b1; #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("[TB] FAIL rst_no_drop got %b exp %b", ctl, CTL_IDLE);
    end
    tick(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret_back_to_back();
    test_discard();
    test_stall();
    test_ignore_in_redirect();
    test_reset_mid_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
